// File: rtl/branch_target_predictor.sv
// Branch target buffer with saturating direction counters for the IF/ID stages.
// The lookup is combinational on pc_i. The ID stage writes back one resolved branch per cycle.
module branch_target_predictor #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  pc_i,
  output logic              hit_o,
  output logic              taken_o,
  output logic [WIDTH-1:0]  target_o,
  input  logic              flush_i,
  input  logic              upd_valid_i,
  input  logic [WIDTH-1:0]  upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [WIDTH-1:0]  upd_target_i,
  input  logic              upd_pred_i,
  output logic [STAT_W-1:0] mispred_cnt_o,
  output logic [STAT_W-1:0] upd_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             unused_pc_lsbs;

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[WIDTH-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[WIDTH-1:IDX_W+2];
  assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

  // Lookup sees table state from the last edge only; a same-cycle update is not bypassed.
  assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign taken_o  = hit_o && cnt_q[lk_idx][CNT_W-1];
  assign target_o = hit_o ? target_q[lk_idx] : '0;

  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Update port: upd_valid_i qualifies one resolved branch per cycle and is always accepted.
  // There is no ready signal. flush_i drops a table write in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          target_q[upd_idx] <= upd_target_i;
          if (cnt_q[upd_idx] != CNT_MAX) cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        cnt_q[upd_idx]    <= CNT_WT;
      end
    end
  end

  // Statistics count every presented update, including ones a flush drops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_cnt_o     <= '0;
      mispred_cnt_o <= '0;
    end else if (upd_valid_i) begin
      if (upd_cnt_o != STAT_MAX) upd_cnt_o <= upd_cnt_o + STAT_W'(1);
      if ((upd_pred_i != upd_taken_i) && (mispred_cnt_o != STAT_MAX))
        mispred_cnt_o <= mispred_cnt_o + STAT_W'(1);
    end
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with saturating direction counters for the 5-stage MIPS pipeline.
- The IF stage looks up the current PC combinationally to get a predicted next PC.
- The ID stage, where branches and jumps resolve, writes the outcome back one update per cycle.
- Extends the fixed predict-not-taken / flush-on-taken scheme with configurable depth, counter width and address width, plus a mispredict statistics counter.

Parameters:
WIDTH, 32, PC/target width in bits
ENTRIES, 16, number of table entries; power of 2, at least 2
CNT_W, 2, direction counter width in bits; at least 1
STAT_W, 32, width of the mispredict and update statistics counters

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
pc_i  input  WIDTH  IF-stage PC to look up
hit_o  output  1  valid entry whose tag matches pc_i
taken_o  output  1  predict taken: hit_o AND counter MSB
target_o  output  WIDTH  stored target of the indexed entry when hit_o=1, else 0
flush_i  input  1  synchronous invalidate of all entries
upd_valid_i  input  1  resolved branch/jump present in ID this cycle
upd_pc_i  input  WIDTH  PC of the resolved instruction
upd_taken_i  input  1  actual outcome
upd_target_i  input  WIDTH  actual target
upd_pred_i  input  1  taken_o value that was used when this instruction was fetched
mispred_cnt_o  output  STAT_W  count of updates with upd_pred_i != upd_taken_i
upd_cnt_o  output  STAT_W  count of accepted updates

Behaviour:
- Address split:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[WIDTH-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target, counter (CNT_W bits).
- Reset (rst_i=0, asynchronous, takes effect immediately):
  - all valid=0, tags=0, targets=0.
  - counters = 2^(CNT_W-1)-1 (weakly not-taken).
  - mispred_cnt_o=0, upd_cnt_o=0.
  - Outputs therefore read hit_o=0, taken_o=0, target_o=0.
- Lookup:
  - Purely combinational, zero latency.
  - Reflects table state as of the last clock edge.
  - No bypass of a same-cycle update.
- Update, at the rising edge when upd_valid_i=1 and flush_i=0:
  - Hit (valid and tag match at the index):
    - counter +1 if taken, saturating at 2^CNT_W-1.
    - counter -1 if not taken, saturating at 0.
    - If taken, target <= upd_target_i.
  - Miss and upd_taken_i=1:
    - Allocate, overwriting any aliasing entry at that index.
    - valid=1, tag and target written, counter = 2^(CNT_W-1) (weakly taken).
  - Miss and upd_taken_i=0: no table change.
- Statistics, whenever upd_valid_i=1 regardless of flush_i:
  - upd_cnt_o increments.
  - mispred_cnt_o increments if upd_pred_i != upd_taken_i.
  - Both saturate at all ones and never wrap.
- flush_i=1 at an edge:
  - All valid bits cleared; counters and targets are left as they are but unreachable.
  - A same-cycle update is dropped; flush wins.
  - Statistics are not cleared.
- Single update port; no write conflicts are possible.
- Reset asserted mid-operation overrides everything in the same instant.

Test Plan:
- Reset released, pc_i=0x40 -> hit_o=0, taken_o=0, target_o=0, both counters 0.
- Update pc 0x40 taken target 0x80, upd_pred_i=0 -> next cycle, pc_i=0x40 gives hit_o=1, taken_o=1, target_o=0x80; mispred_cnt_o=1, upd_cnt_o=1.
- Three not-taken updates at 0x40 -> counter 2→1→0→0; taken_o=0 after the first; then two taken updates -> counter 1, then 2; taken_o=1 only after the second.
- Update pc 0x80 (same index 0, tag 2) taken target 0x100 -> lookup 0x40 gives hit_o=0; lookup 0x80 gives hit_o=1, target_o=0x100.
- Not-taken update at miss pc 0x44 -> lookup 0x44 stays hit_o=0; upd_cnt_o increments.
- flush_i together with upd_valid_i (pc 0x48 taken) -> all lookups hit_o=0, 0x48 not allocated, statistics incremented; then rst_i low mid-cycle -> counters read 0 immediately, before any clock edge.
